gtx_rx_frame_chk: RTL and testbench
===================================

GTX_RX_FRAME_CHK -- requirements
Module: gtx_rx_frame_chk

Interface
REQ-001 SHALL have parameter IDLE, default 16'hBC50, meaning the idle word; upper byte is K28.5 with rx_char=2'b10.
REQ-002 SHALL have parameter SOF, default 16'hFB00, meaning the start-of-frame word with rx_char=2'b10.
REQ-003 SHALL have parameter EOF, default 16'hFD00, meaning the end-of-frame word with rx_char=2'b10.
REQ-004 SHALL have port usrclk  input  1  single clock (GTX rxusrclk2 domain); all logic on rising edge.
REQ-005 SHALL have port usrrst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_data  input  16  received word from the GTX lane.
REQ-007 SHALL have port rx_char  input  2  per-byte K flags; bit1 is rx_data[15:8], bit0 is rx_data[7:0].
REQ-008 SHALL have port clr  input  1  synchronous clear of der and frm_cnt.
REQ-009 SHALL have port lock  output  1  lane locked to the idle/frame stream.
REQ-010 SHALL have port byte_swap  output  1  byte aligner is swapping lanes.
REQ-011 SHALL have port err_flag  output  1  one-cycle pulse per erroneous word.
REQ-012 SHALL have port der  output  16  accumulated error-word count, saturating.
REQ-013 SHALL have port frm_cnt  output  16  count of good frames, wrapping.
REQ-014 SHALL have port len_last  output  8  payload length of the last good frame.

Function
REQ-015 SHALL implement the receive end of the frame format: IDLE*, SOF, HDR={len,~len} with k=00 and len 1..255, len payload words incrementing from 16'h0000 with k=00, then EOF.
REQ-016 SHALL register the input in stage 1, producing aligned word w/k.
- No swap: w=rx_data, k=rx_char.
- Swap: w={prev[7:0],cur[15:8]}, with k formed the same way.
REQ-017 SHALL set the byte_swap state only in UNLOCK.
- Set to 1 on rx_char=2'b01 with rx_data[7:0]=IDLE[15:8].
- Clear to 0 on rx_char=2'b10 with rx_data[15:8]=IDLE[15:8].
REQ-018 SHALL implement the FSM states UNLOCK, IDLE, HDR, PAY and EOF_CHK, checked in stage 2.
REQ-019 SHALL behave in UNLOCK as follows: 16 consecutive w=IDLE,k=10 go to IDLE with lock=1; any other word resets the run count; no errors are counted.
REQ-020 SHALL behave in IDLE as follows: IDLE word stays; SOF goes to HDR; any other word is an error and stays.
REQ-021 SHALL behave in HDR as follows: w[7:0]=~w[15:8], len!=0 and k=00 loads len, clears exp to 0 and goes to PAY; otherwise error and go to IDLE.
REQ-022 SHALL behave in PAY as follows: compare w against exp and k against 00; a mismatch is an error but the FSM continues; exp increments every word; after len words go to EOF_CHK.
REQ-023 SHALL behave in EOF_CHK as follows: EOF increments frm_cnt, loads len_last and goes to IDLE; otherwise error and go to IDLE.
REQ-024 SHALL assert err_flag on the second usrclk edge after the offending word is sampled (2-cycle latency), and increment der at the same edge.
REQ-025 SHALL saturate der at 16'hFFFF and wrap frm_cnt from 16'hFFFF to 0.
REQ-026 SHALL go to UNLOCK on 4 consecutive error words while locked, deasserting lock on the same edge as the 4th err_flag; any good word clears the consecutive count.
REQ-027 SHALL give clr priority over a simultaneous increment: der and frm_cnt become 0; err_flag still pulses.
REQ-028 SHALL leave lock, FSM state and len_last unaffected by clr.

Reset
REQ-029 SHALL, while usrrst_n=0, immediately force lock=0, byte_swap=0, err_flag=0, der=0, frm_cnt=0, len_last=0, FSM=UNLOCK, and all pipeline and counter registers to 0.
REQ-030 SHALL, on reset mid-frame, discard the partial frame without counting an error; after release the block SHALL need 16 idles to relock.

Configuration
REQ-031 SHALL use the macro GTX_RX_BYTE_ALIGN_EN.
- Defined: the aligner of REQ-016/017 is compiled in.
- Undefined: byte_swap is tied to 0, the stage-1 register passes the word straight through, latency is unchanged, and a comma in the low byte never allows lock.

Verification
REQ-032 SHALL cover: 16 IDLE words (16'hBC50, k=10) -> lock=1 two cycles after the 16th; der=0.
REQ-033 SHALL cover: after lock, frame SOF, 16'h03FC, 0000, 0001, 0002, EOF -> frm_cnt=1, len_last=3, no err_flag.
REQ-034 SHALL cover: same frame with payload word 2 = 16'h0005 -> exactly one err_flag pulse, der=1, frm_cnt=1.
REQ-035 SHALL cover: byte-shifted idles 16'h50BC with k=01 (macro defined) -> byte_swap=1 and lock=1; macro undefined -> lock stays 0.
REQ-036 SHALL cover: while locked, 4 words 16'h1234 (k=00) -> 4 err_flag pulses, der=4, lock=0 with the 4th pulse.
REQ-037 SHALL cover: der at 16'hFFFF plus another error -> der stays 16'hFFFF; clr on the same cycle -> der=0.

Source files
------------

// File: rtl/gtx_rx_frame_chk.sv
// Receive-side frame checker for a 16-bit GTX lane: idle lock, SOF/HDR/payload/EOF checking, error and frame counters.
// Optional byte aligner compiled in with GTX_RX_BYTE_ALIGN_EN.
module gtx_rx_frame_chk #(
  parameter logic [15:0] IDLE = 16'hBC50,
  parameter logic [15:0] SOF  = 16'hFB00,
  parameter logic [15:0] EOF  = 16'hFD00
) (
  input  logic        usrclk,
  input  logic        usrrst_n,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_char,
  input  logic        clr,
  output logic        lock,
  output logic        byte_swap,
  output logic        err_flag,
  output logic [15:0] der,
  output logic [15:0] frm_cnt,
  output logic [7:0]  len_last
);

  localparam int unsigned W_WORD = 16;
  localparam int unsigned W_LEN  = 8;
  localparam int unsigned W_RUN  = 4;

  typedef enum logic [2:0] {
    ST_UNLOCK,
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_EOF_CHK
  } state_t;

  state_t              state_q, state_n;
  logic [W_WORD-1:0]   w_q;
  logic [1:0]          k_q;
  logic [W_RUN-1:0]    run_q, run_n;
  logic [1:0]          err_run_q, err_run_n;
  logic [W_LEN-1:0]    len_q, len_n;
  logic [W_WORD-1:0]   exp_q, exp_n;
  logic [W_WORD-1:0]   der_q, der_n;
  logic [W_WORD-1:0]   frm_q, frm_n;
  logic [W_LEN-1:0]    len_last_q, len_last_n;
  logic                lock_q, lock_n;
  logic                err_q, err_c;
  logic                is_idle_c;

`ifdef GTX_RX_BYTE_ALIGN_EN
  logic [7:0] prev_d_q;
  logic       prev_k_q;
  logic       swap_q, swap_n;

  // Swap state only moves while hunting for lock.
  always_comb begin
    swap_n = swap_q;
    if (state_q == ST_UNLOCK) begin
      if (rx_char == 2'b01 && rx_data[7:0] == IDLE[15:8]) begin
        swap_n = 1'b1;
      end else if (rx_char == 2'b10 && rx_data[15:8] == IDLE[15:8]) begin
        swap_n = 1'b0;
      end
    end
  end

  // Stage 1: aligned word built from the previous low byte and the current high byte when swapped.
  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      w_q      <= '0;
      k_q      <= '0;
      prev_d_q <= '0;
      prev_k_q <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      w_q      <= swap_q ? {prev_d_q, rx_data[15:8]} : rx_data;
      k_q      <= swap_q ? {prev_k_q, rx_char[1]} : rx_char;
      prev_d_q <= rx_data[7:0];
      prev_k_q <= rx_char[0];
      swap_q   <= swap_n;
    end
  end

  assign byte_swap = swap_q;
`else
  // Stage 1: straight pass-through register.
  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      w_q <= '0;
      k_q <= '0;
    end else begin
      w_q <= rx_data;
      k_q <= rx_char;
    end
  end

  assign byte_swap = 1'b0;
`endif

  assign is_idle_c = (w_q == IDLE) && (k_q == 2'b10);

  // Stage 2: next-state, counters and error detection.
  always_comb begin
    state_n    = state_q;
    run_n      = run_q;
    err_run_n  = err_run_q;
    len_n      = len_q;
    exp_n      = exp_q;
    der_n      = der_q;
    frm_n      = frm_q;
    len_last_n = len_last_q;
    err_c      = 1'b0;

    unique case (state_q)
      ST_UNLOCK: begin
        if (is_idle_c) begin
          if (run_q == W_RUN'(15)) begin
            state_n = ST_IDLE;
            run_n   = '0;
          end else begin
            run_n = run_q + W_RUN'(1);
          end
        end else begin
          run_n = '0;
        end
      end
      ST_IDLE: begin
        if (w_q == SOF && k_q == 2'b10) begin
          state_n = ST_HDR;
        end else if (!is_idle_c) begin
          err_c = 1'b1;
        end
      end
      ST_HDR: begin
        if (w_q[7:0] == ~w_q[15:8] && w_q[15:8] != 8'd0 && k_q == 2'b00) begin
          len_n   = w_q[15:8];
          exp_n   = '0;
          state_n = ST_PAY;
        end else begin
          err_c   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_PAY: begin
        if (w_q != exp_q || k_q != 2'b00) begin
          err_c = 1'b1;
        end
        exp_n = exp_q + W_WORD'(1);
        if (exp_q[7:0] == len_q - W_LEN'(1)) begin
          state_n = ST_EOF_CHK;
        end
      end
      ST_EOF_CHK: begin
        if (w_q == EOF && k_q == 2'b10) begin
          frm_n      = frm_q + W_WORD'(1);
          len_last_n = len_q;
        end else begin
          err_c = 1'b1;
        end
        state_n = ST_IDLE;
      end
      default: state_n = ST_UNLOCK;
    endcase

    // Saturating error count; four consecutive bad words drop lock.
    if (err_c) begin
      if (der_q != 16'hFFFF) begin
        der_n = der_q + W_WORD'(1);
      end
      if (err_run_q == 2'd3) begin
        state_n   = ST_UNLOCK;
        err_run_n = '0;
        run_n     = '0;
      end else begin
        err_run_n = err_run_q + 2'd1;
      end
    end else begin
      err_run_n = '0;
    end

    if (clr) begin
      der_n = '0;
      frm_n = '0;
    end

    lock_n = (state_n != ST_UNLOCK);
  end

  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      state_q    <= ST_UNLOCK;
      run_q      <= '0;
      err_run_q  <= '0;
      len_q      <= '0;
      exp_q      <= '0;
      der_q      <= '0;
      frm_q      <= '0;
      len_last_q <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      run_q      <= run_n;
      err_run_q  <= err_run_n;
      len_q      <= len_n;
      exp_q      <= exp_n;
      der_q      <= der_n;
      frm_q      <= frm_n;
      len_last_q <= len_last_n;
      lock_q     <= lock_n;
      err_q      <= err_c;
    end
  end

  assign lock     = lock_q;
  assign err_flag = err_q;
  assign der      = der_q;
  assign frm_cnt  = frm_q;
  assign len_last = len_last_q;

endmodule

// File: tb/tb_gtx_rx_frame_chk.sv
// Directed self-checking bench for gtx_rx_frame_chk; expectations follow GTX_RX_BYTE_ALIGN_EN.
module tb_gtx_rx_frame_chk;

  localparam logic [15:0] W_IDLE = 16'hBC50;
  localparam logic [15:0] W_SOF  = 16'hFB00;
  localparam logic [15:0] W_EOF  = 16'hFD00;

  logic        usrclk = 1'b0;
  logic        usrrst_n;
  logic [15:0] rx_data;
  logic [1:0]  rx_char;
  logic        clr;
  logic        lock;
  logic        byte_swap;
  logic        err_flag;
  logic [15:0] der;
  logic [15:0] frm_cnt;
  logic [7:0]  len_last;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  int e0;

  gtx_rx_frame_chk dut (
    .usrclk    (usrclk),
    .usrrst_n  (usrrst_n),
    .rx_data   (rx_data),
    .rx_char   (rx_char),
    .clr       (clr),
    .lock      (lock),
    .byte_swap (byte_swap),
    .err_flag  (err_flag),
    .der       (der),
    .frm_cnt   (frm_cnt),
    .len_last  (len_last)
  );

  always #5 usrclk = ~usrclk;

  always @(negedge usrclk) if (err_flag === 1'b1) err_pulses++;

  task automatic step(input logic [15:0] d, input logic [1:0] c);
    rx_data = d;
    rx_char = c;
    @(posedge usrclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    usrrst_n = 1'b0;
    clr      = 1'b0;
    rx_data  = W_IDLE;
    rx_char  = 2'b10;
    #2;
    chk("rst_lock", 16'(lock), 16'd0);
    chk("rst_swap", 16'(byte_swap), 16'd0);
    chk("rst_err", 16'(err_flag), 16'd0);
    chk("rst_der", der, 16'd0);
    chk("rst_frm", frm_cnt, 16'd0);
    chk("rst_len_last", 16'(len_last), 16'd0);
    @(posedge usrclk); #1;
    usrrst_n = 1'b1;

    // Initial lock: 16 idles, lock two cycles after the 16th
    for (int i = 0; i < 16; i++) step(W_IDLE, 2'b10);
    chk("lock_before", 16'(lock), 16'd0);
    step(W_IDLE, 2'b10);
    chk("lock_after16", 16'(lock), 16'd1);
    chk("der_after_lock", der, 16'd0);

    // Good frame, len 3
    e0 = err_pulses;
    step(W_SOF, 2'b10); step(16'h03FC, 2'b00);
    step(16'h0000, 2'b00); step(16'h0001, 2'b00); step(16'h0002, 2'b00);
    step(W_EOF, 2'b10); step(W_IDLE, 2'b10); step(W_IDLE, 2'b10);
    chk("good_frm", frm_cnt, 16'd1);
    chk("good_len_last", 16'(len_last), 16'd3);
    chk("good_no_err", 16'(err_pulses - e0), 16'd0);
    chk("good_der", der, 16'd0);

    // clr clears counters only
    clr = 1'b1; step(W_IDLE, 2'b10); clr = 1'b0;
    chk("clr_frm", frm_cnt, 16'd0);
    chk("clr_len_last", 16'(len_last), 16'd3);
    chk("clr_lock", 16'(lock), 16'd1);

    // Frame with bad payload word 2
    e0 = err_pulses;
    step(W_SOF, 2'b10); step(16'h03FC, 2'b00);
    step(16'h0000, 2'b00); step(16'h0001, 2'b00); step(16'h0005, 2'b00);
    chk("bad_pay_err_early", 16'(err_flag), 16'd0);
    step(W_EOF, 2'b10);
    chk("bad_pay_err_timing", 16'(err_flag), 16'd1);
    step(W_IDLE, 2'b10);
    chk("bad_pay_err_one", 16'(err_flag), 16'd0);
    step(W_IDLE, 2'b10);
    chk("bad_pay_pulses", 16'(err_pulses - e0), 16'd1);
    chk("bad_pay_der", der, 16'd1);
    chk("bad_pay_frm", frm_cnt, 16'd1);

    // Four consecutive errors drop lock with the 4th pulse
    clr = 1'b1; step(W_IDLE, 2'b10); clr = 1'b0;
    e0 = err_pulses;
    step(16'h1234, 2'b00); step(16'h1234, 2'b00);
    chk("err4_first_pulse", 16'(err_flag), 16'd1);
    step(16'h1234, 2'b00); step(16'h1234, 2'b00);
    chk("err4_lock_held", 16'(lock), 16'd1);
    chk("err4_der3", der, 16'd3);
    step(W_IDLE, 2'b10);
    chk("err4_fourth_pulse", 16'(err_flag), 16'd1);
    chk("err4_der", der, 16'd4);
    chk("err4_unlock", 16'(lock), 16'd0);
    step(W_IDLE, 2'b10);
    chk("err4_pulses", 16'(err_pulses - e0), 16'd4);

    // Relock, then malformed headers
    for (int i = 0; i < 18; i++) step(W_IDLE, 2'b10);
    chk("relock", 16'(lock), 16'd1);
    e0 = err_pulses;
    step(W_SOF, 2'b10); step(16'h0300, 2'b00); step(W_IDLE, 2'b10); step(W_IDLE, 2'b10);
    step(W_SOF, 2'b10); step(16'h00FF, 2'b00); step(W_IDLE, 2'b10); step(W_IDLE, 2'b10);
    chk("hdr_err_pulses", 16'(err_pulses - e0), 16'd2);
    chk("hdr_err_der", der, 16'd6);
    chk("hdr_err_lock", 16'(lock), 16'd1);

    // Saturation at FFFF, then clr wins over a simultaneous increment
    clr = 1'b1; step(W_IDLE, 2'b10); clr = 1'b0;
    force dut.der_q = 16'hFFFE;
    step(W_IDLE, 2'b10);
    release dut.der_q;
    chk("sat_preload", der, 16'hFFFE);
    step(16'h1234, 2'b00); step(16'h1234, 2'b00);
    chk("sat_reach", der, 16'hFFFF);
    step(16'h1234, 2'b00);
    chk("sat_hold", der, 16'hFFFF);
    chk("sat_hold_err", 16'(err_flag), 16'd1);
    clr = 1'b1; step(W_IDLE, 2'b10); clr = 1'b0;
    chk("clr_prio_der", der, 16'd0);
    chk("clr_prio_err", 16'(err_flag), 16'd1);
    step(W_IDLE, 2'b10);
    chk("clr_prio_lock", 16'(lock), 16'd1);

    // Reset mid-frame
    step(W_SOF, 2'b10); step(16'h03FC, 2'b00); step(16'h0000, 2'b00);
    usrrst_n = 1'b0;
    #1;
    chk("midrst_lock", 16'(lock), 16'd0);
    chk("midrst_err", 16'(err_flag), 16'd0);
    chk("midrst_len_last", 16'(len_last), 16'd0);
    e0 = err_pulses;
    @(posedge usrclk); #1;
    usrrst_n = 1'b1;

    // Byte-shifted idles
    for (int i = 0; i < 20; i++) step(16'h50BC, 2'b01);
    chk("shift_no_err", 16'(err_pulses - e0), 16'd0);
`ifdef GTX_RX_BYTE_ALIGN_EN
    chk("shift_swap", 16'(byte_swap), 16'd1);
    chk("shift_lock", 16'(lock), 16'd1);
`else
    chk("shift_swap", 16'(byte_swap), 16'd0);
    chk("shift_lock", 16'(lock), 16'd0);
    for (int i = 0; i < 16; i++) step(W_IDLE, 2'b10);
    chk("postrst_lock_before", 16'(lock), 16'd0);
    step(W_IDLE, 2'b10);
    chk("postrst_lock_after", 16'(lock), 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
